pe_mac_unit: RTL and testbench

Parametrised multiply-accumulate processing element, the successor to the fixed 8-bit/24-bit PE.
- Accepts a run-time-configurable number of signed operand pairs over a valid/ready stream.
- Accumulates their products at configurable width, with selectable saturation.
- Presents the result on a valid/ready output port.
- Tiled into the NPU PE array; fed by the operand scheduler, drained by the result collector.

---
 rtl/pe_pkg.sv | 23 ++
 rtl/pe_mac_unit_if.sv | 25 ++
 rtl/pe_sat_add.sv | 27 ++
 rtl/pe_mac_unit.sv | 131 +++++++++++++
 tb/tb_pe_mac_unit.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// Shared types and constants for the MAC processing element.
// Accumulator limits are derived from ACC_W so every instance agrees on clamp values.
package pe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } pe_state_e;

  localparam int PE_MAX_ACC_W = 64;

  // Largest positive w-bit two's-complement value, zero-extended to 64 bits.
  function automatic logic [PE_MAX_ACC_W-1:0] acc_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative w-bit value; only the low w bits are meaningful.
  function automatic logic [PE_MAX_ACC_W-1:0] acc_min(input int w);
    return ~acc_max(w);
  endfunction

endpackage

// File: rtl/pe_mac_unit_if.sv
// Operand and result streams of the MAC PE.
// The slave modport is the PE side, the master modport is the scheduler/collector side.
interface pe_mac_unit_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              ovf;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, ovf
  );
endinterface

// File: rtl/pe_sat_add.sv
// Combinational ACC_W signed adder with optional clamp on overflow.
// The overflow flag is raised in both modes; only the sum differs.
module pe_sat_add
  import pe_pkg::*;
#(
  parameter int ACC_W    = 24,
  parameter int SATURATE = 1
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);
  localparam logic [ACC_W-1:0] MAXV = ACC_W'(acc_max(ACC_W));
  localparam logic [ACC_W-1:0] MINV = ACC_W'(acc_min(ACC_W));

  logic [ACC_W-1:0] raw;

  assign raw = a + b;
  // Same-sign addends producing an opposite-sign result is the only overflow case.
  assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);

  always_comb begin
    sum = raw;
    if ((SATURATE != 0) && ovf) sum = a[ACC_W-1] ? MINV : MAXV;
  end
endmodule

// File: rtl/pe_mac_unit.sv
// Run-length MAC processing element: accumulates len signed products, then
// presents the sum (and sticky overflow) on a valid/ready result port.
module pe_mac_unit
  import pe_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24,
  parameter int LEN_W    = 8,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  pe_mac_unit_if.slave     bus,
  output logic             busy,
  output logic             done
);
  pe_state_e          state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   res_q, res_d;
  logic               rovf_q, rovf_d;

  logic signed [DATA_W-1:0]   a_s, b_s;
  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]           prod_ext;
  logic [ACC_W-1:0]           add_sum;
  logic                       add_ovf;
  logic [LEN_W-1:0]           cnt_inc;
  logic                       beat;

  assign a_s      = bus.in_a;
  assign b_s      = bus.in_b;
  assign prod     = a_s * b_s;
  assign prod_ext = ACC_W'(prod);
  assign cnt_inc  = cnt_q + LEN_W'(1);

  pe_sat_add #(
    .ACC_W   (ACC_W),
    .SATURATE(SATURATE)
  ) u_add (
    .a  (acc_q),
    .b  (prod_ext),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  assign bus.in_ready  = (state_q == ST_CALC);
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.out_data  = res_q;
  assign bus.ovf       = rovf_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_OUT) && bus.out_ready && !abort;
  assign beat          = (state_q == ST_CALC) && bus.in_valid;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    rovf_d  = rovf_q;
    if (abort) begin
      // Result registers keep their old value; only the run state is dropped.
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_d = len;
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
            if (len == '0) begin
              state_d = ST_OUT;
              res_d   = '0;
              rovf_d  = 1'b0;
            end else begin
              state_d = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (beat) begin
            acc_d = add_sum;
            cnt_d = cnt_inc;
            ovf_d = ovf_q | add_ovf;
            // Result is captured here so out_valid rises the cycle after the last beat.
            if (cnt_inc == len_q) begin
              state_d = ST_OUT;
              res_d   = add_sum;
              rovf_d  = ovf_q | add_ovf;
            end
          end
        end
        ST_OUT: begin
          if (bus.out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      rovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      rovf_q  <= rovf_d;
    end
  end
endmodule

// File: tb/tb_pe_mac_unit.sv
// Bench for pe_mac_unit: a saturating and a wrapping instance share stimulus and are
// checked every cycle against an integer-arithmetic run model.
module tb_pe_mac_unit;
  localparam int     DW   = 8;
  localparam int     AW   = 16;
  localparam int     LW   = 8;
  localparam longint AMAX = 32767;
  localparam longint AMIN = -32768;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [LW-1:0] len = '0;
  logic [DW-1:0] in_a = '0, in_b = '0;
  logic          busy_s, done_s, busy_w, done_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pe_mac_unit_if #(.DATA_W(DW), .ACC_W(AW)) if_s ();
  pe_mac_unit_if #(.DATA_W(DW), .ACC_W(AW)) if_w ();

  assign if_s.in_valid  = in_valid;
  assign if_s.in_a      = in_a;
  assign if_s.in_b      = in_b;
  assign if_s.out_ready = out_ready;
  assign if_w.in_valid  = in_valid;
  assign if_w.in_a      = in_a;
  assign if_w.in_b      = in_b;
  assign if_w.out_ready = out_ready;

  pe_mac_unit #(.DATA_W(DW), .ACC_W(AW), .LEN_W(LW), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .bus(if_s), .busy(busy_s), .done(done_s));

  pe_mac_unit #(.DATA_W(DW), .ACC_W(AW), .LEN_W(LW), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .bus(if_w), .busy(busy_w), .done(done_w));

  // Run model: is a run collecting beats, is a result on offer, and the true sums.
  bit     m_run, m_pres, ovf_s, ovf_w, rovf_s, rovf_w;
  int     m_len, m_cnt, m_ndone;
  longint acc_s, acc_w, res_s, res_w, prod;

  task automatic model_clear();
    m_run = 0; m_pres = 0; m_cnt = 0; acc_s = 0; acc_w = 0;
    ovf_s = 0; ovf_w = 0; res_s = 0; res_w = 0; rovf_s = 0; rovf_w = 0;
  endtask

  task automatic model_step();
    if (!rst) begin
      model_clear();
    end else if (abort) begin
      m_run = 0; m_pres = 0; m_cnt = 0; acc_s = 0; acc_w = 0; ovf_s = 0; ovf_w = 0;
    end else if (m_run) begin
      if (in_valid) begin
        prod  = longint'($signed(in_a)) * longint'($signed(in_b));
        acc_s = acc_s + prod;
        if (acc_s > AMAX) begin acc_s = AMAX; ovf_s = 1; end
        else if (acc_s < AMIN) begin acc_s = AMIN; ovf_s = 1; end
        acc_w = acc_w + prod;
        if (acc_w > AMAX) begin acc_w = acc_w - 65536; ovf_w = 1; end
        else if (acc_w < AMIN) begin acc_w = acc_w + 65536; ovf_w = 1; end
        m_cnt++;
        if (m_cnt == m_len) begin
          m_run = 0; m_pres = 1;
          res_s = acc_s; rovf_s = ovf_s; res_w = acc_w; rovf_w = ovf_w;
        end
      end
    end else if (m_pres) begin
      if (out_ready) begin m_pres = 0; m_ndone++; end
    end else if (start) begin
      m_len = int'(len); m_cnt = 0; acc_s = 0; acc_w = 0; ovf_s = 0; ovf_w = 0;
      if (len == '0) begin
        m_pres = 1; res_s = 0; res_w = 0; rovf_s = 0; rovf_w = 0;
      end else begin
        m_run = 1;
      end
    end
  endtask

  initial begin
    model_clear();
    m_ndone = 0; m_len = 0;
    forever begin
      @(posedge clk or negedge rst);
      model_step();
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_dut(input string tag, input logic iv, input logic ov, input logic bz,
                         input logic dn, input logic [AW-1:0] d, input logic o,
                         input longint er, input bit eo);
    chk({tag, "_in_ready"}, longint'(iv), longint'(m_run));
    chk({tag, "_out_valid"}, longint'(ov), longint'(m_pres));
    chk({tag, "_busy"}, longint'(bz), longint'(m_run | m_pres));
    chk({tag, "_done"}, longint'(dn), longint'(m_pres && out_ready && !abort));
    if (m_pres) begin
      chk({tag, "_out_data"}, longint'($signed(d)), er);
      chk({tag, "_ovf"}, longint'(o), longint'(eo));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        cmp_dut("sat", if_s.in_ready, if_s.out_valid, busy_s, done_s, if_s.out_data, if_s.ovf,
                res_s, rovf_s);
        cmp_dut("wrap", if_w.in_ready, if_w.out_valid, busy_w, done_w, if_w.out_data, if_w.ovf,
                res_w, rovf_w);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int a, input int b);
    in_valid = 1'b1; in_a = DW'(a); in_b = DW'(b);
    tick();
  endtask

  task automatic begin_run(input int l);
    start = 1'b1; len = LW'(l);
    tick();
    start = 1'b0;
  endtask

  // Drains until the model is idle again; an expired budget counts as a failure.
  task automatic finish_run(input int vpct, input int rpct, input int apct, input int budget);
    int cyc;
    cyc = 0;
    while ((m_run || m_pres) && cyc < budget) begin
      in_valid  = ($urandom_range(99) < vpct);
      in_a      = DW'($urandom_range(255));
      in_b      = DW'($urandom_range(255));
      out_ready = ($urandom_range(99) < rpct);
      abort     = ($urandom_range(999) < apct);
      tick();
      cyc++;
    end
    abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    if (cyc >= budget) chk("run_timeout", longint'(cyc), longint'(budget - 1));
  endtask

  logic [AW-1:0] held;

  initial begin
    // Reset state
    #2;
    chk("rst_in_ready", longint'(if_s.in_ready), 0);
    chk("rst_out_valid", longint'(if_s.out_valid), 0);
    chk("rst_busy", longint'(busy_s), 0);
    chk("rst_done", longint'(done_s), 0);
    chk("rst_out_data", longint'(if_s.out_data), 0);
    chk("rst_ovf", longint'(if_s.ovf), 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Basic run: 2*3 - 4*5 + 7*7 = 35
    begin_run(3);
    beat(2, 3); beat(-4, 5); beat(7, 7);
    in_valid = 1'b0;
    chk("t1_out_valid", longint'(if_s.out_valid), 1);
    chk("t1_out_data", longint'($signed(if_s.out_data)), 35);
    chk("t1_ovf", longint'(if_s.ovf), 0);
    chk("t1_no_done_yet", longint'(done_s), 0);
    out_ready = 1'b1;
    #1;
    chk("t1_done", longint'(done_s), 1);
    tick();
    out_ready = 1'b0;
    chk("t1_done_gone", longint'(done_s), 0);
    chk("t1_valid_gone", longint'(if_s.out_valid), 0);

    // Input stalls then an output stall of 5 cycles
    begin_run(4);
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0); in_a = DW'($urandom_range(255)); in_b = DW'($urandom_range(255));
      tick();
    end
    in_valid = 1'b0;
    chk("t2_out_valid", longint'(if_s.out_valid), 1);
    held = if_s.out_data;
    repeat (5) tick();
    chk("t2_data_stable", longint'(if_s.out_data), longint'(held));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Saturation vs wrap: four (-128,-128) products of 16384
    begin_run(4);
    repeat (4) beat(-128, -128);
    in_valid = 1'b0;
    chk("t3_sat_data", longint'($signed(if_s.out_data)), 32767);
    chk("t3_sat_ovf", longint'(if_s.ovf), 1);
    chk("t3_wrap_data", longint'($signed(if_w.out_data)), 0);
    chk("t3_wrap_ovf", longint'(if_w.ovf), 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // len = 0 with operands offered: no beat taken, zero result
    in_valid = 1'b1; in_a = DW'(9); in_b = DW'(9);
    begin_run(0);
    chk("t4_out_valid", longint'(if_s.out_valid), 1);
    chk("t4_in_ready", longint'(if_s.in_ready), 0);
    chk("t4_out_data", longint'(if_s.out_data), 0);
    in_valid = 1'b0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Abort mid-run, then a single-beat run
    begin_run(5);
    beat(10, 10); beat(10, 10);
    abort = 1'b1; in_valid = 1'b1;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("t5_busy", longint'(busy_s), 0);
    chk("t5_out_valid", longint'(if_s.out_valid), 0);
    tick(); tick();
    begin_run(1);
    beat(3, -3);
    in_valid = 1'b0;
    chk("t5_out_data", longint'($signed(if_s.out_data)), -9);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Asynchronous reset during CALC
    begin_run(4);
    beat(5, 5); in_valid = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t6_rst_in_ready", longint'(if_s.in_ready), 0);
    chk("t6_rst_busy", longint'(busy_s), 0);
    chk("t6_rst_done", longint'(done_s), 0);
    chk("t6_rst_out_data", longint'(if_s.out_data), 0);
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Start while busy must not relatch len
    begin_run(3);
    start = 1'b1; len = LW'(1);
    beat(1, 2);
    chk("t6_ignored_start", longint'(if_s.out_valid), 0);
    start = 1'b0;
    beat(3, 4); beat(5, 6);
    in_valid = 1'b0;
    chk("t6_len_kept", longint'(if_s.out_valid), 1);
    chk("t6_out_data", longint'($signed(if_s.out_data)), 44);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Randomized runs, including the maximum run length
    for (int r = 0; r < 25; r++) begin
      begin_run((r == 7) ? 255 : int'($urandom_range(9)));
      finish_run(75, 50, 15, 1500);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
